pipe_stage_hs: RTL and testbench

PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

---
 rtl/pipe_stage_hs.sv | 100 ++++++++++
 tb/tb_pipe_stage_hs.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// Two-entry skid-buffered pipeline stage with a valid/ready handshake on both sides.
// in_ready depends only on registered state, so upstream never sees out_ready combinationally.
module pipe_stage_hs #(
    parameter int WIDTH       = 32,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               push, pop;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign stall_cnt = stall_q;
    assign out_data  = (ZERO_BUBBLE != 0 && !out_valid) ? '0 : main_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end

        // Flush wins over any simultaneous push/pop; a popped head is already gone downstream.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: three instances (default, 4-bit counter, no bubble zeroing)
// share stimulus; a per-cycle vector table plus hand sequences for saturation and reset.
module tb_pipe_stage_hs;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic        a_in_ready, a_out_valid;
    logic [7:0]  a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall;

    logic        s_in_ready, s_out_valid;
    logic [7:0]  s_out_data;
    logic [1:0]  s_occ;
    logic [3:0]  s_stall;

    logic        n_in_ready, n_out_valid;
    logic [7:0]  n_out_data;
    logic [1:0]  n_occ;
    logic [15:0] n_stall;

    int passed;
    int total;

    pipe_stage_hs #(.WIDTH(8), .ZERO_BUBBLE(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_hs #(.WIDTH(8), .ZERO_BUBBLE(1), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .occupancy(s_occ), .stall_cnt(s_stall)
    );

    pipe_stage_hs #(.WIDTH(8), .ZERO_BUBBLE(0), .CNT_W(16)) u_nb (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
        .occupancy(n_occ), .stall_cnt(n_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [7:0]  din;
        logic        ordy;
        logic        fl;
        logic [1:0]  occ;    // expected occupancy after the edge
        logic [7:0]  main;   // expected head register after the edge
        logic [15:0] stall;  // expected stall count after the edge
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;

        // streaming
        vecs[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 2'd1, 8'h11, 16'd0};
        vecs[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 2'd1, 8'h22, 16'd0};
        vecs[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 2'd1, 8'h33, 16'd0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h33, 16'd0};
        // back-pressure, 0x0C held off while full
        vecs[4]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 2'd1, 8'h0A, 16'd0};
        vecs[5]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 2'd2, 8'h0A, 16'd1};
        vecs[6]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 2'd2, 8'h0A, 16'd2};
        vecs[7]  = '{1'b1, 8'h0C, 1'b1, 1'b0, 2'd1, 8'h0B, 16'd2};
        vecs[8]  = '{1'b1, 8'h0C, 1'b1, 1'b0, 2'd1, 8'h0C, 16'd2};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h0C, 16'd2};
        // flush from FULL with 0xDD offered
        vecs[10] = '{1'b1, 8'h01, 1'b0, 1'b0, 2'd1, 8'h01, 16'd2};
        vecs[11] = '{1'b1, 8'h02, 1'b0, 1'b0, 2'd2, 8'h01, 16'd3};
        vecs[12] = '{1'b1, 8'hDD, 1'b0, 1'b1, 2'd0, 8'h01, 16'd4};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h01, 16'd4};
        // flush coinciding with a pop: popped head must not come back
        vecs[14] = '{1'b1, 8'h44, 1'b1, 1'b0, 2'd1, 8'h44, 16'd4};
        vecs[15] = '{1'b1, 8'h55, 1'b1, 1'b1, 2'd0, 8'h44, 16'd4};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h44, 16'd4};
        // bubble: push then drain
        vecs[17] = '{1'b1, 8'h5A, 1'b0, 1'b0, 2'd1, 8'h5A, 16'd4};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 8'h5A, 16'd4};

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_occ", 32'(a_occ), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_nb_data", 32'(n_out_data), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].iv, vecs[i].din, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("v%0d_occ", i), 32'(a_occ), 32'(vecs[i].occ));
            chk($sformatf("v%0d_out_valid", i), 32'(a_out_valid), 32'(vecs[i].occ != 2'd0));
            chk($sformatf("v%0d_in_ready", i), 32'(a_in_ready), 32'(vecs[i].occ != 2'd2));
            chk($sformatf("v%0d_out_data", i), 32'(a_out_data),
                (vecs[i].occ != 2'd0) ? 32'(vecs[i].main) : 32'h0);
            chk($sformatf("v%0d_nb_data", i), 32'(n_out_data), 32'(vecs[i].main));
            chk($sformatf("v%0d_stall", i), 32'(a_stall), 32'(vecs[i].stall));
            chk($sformatf("v%0d_sat_stall", i), 32'(s_stall), 32'(vecs[i].stall));
        end

        // saturation: one entry held with out_ready low
        step(1'b1, 8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("sat_stall_15", 32'(s_stall), 32'd15);
        chk("sat_wide_stall", 32'(a_stall), 32'd24);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("sat_stall_holds", 32'(s_stall), 32'd15);
        chk("sat_wide_stall2", 32'(a_stall), 32'd27);
        chk("sat_head", 32'(a_out_data), 32'h77);

        // asynchronous reset from FULL, asserted between edges
        step(1'b1, 8'h81, 1'b0, 1'b0);
        chk("pre_rst_occ", 32'(a_occ), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_occ", 32'(a_occ), 32'd0);
        chk("arst_out_valid", 32'(a_out_valid), 32'd0);
        chk("arst_in_ready", 32'(a_in_ready), 32'd1);
        chk("arst_stall", 32'(a_stall), 32'd0);
        chk("arst_out_data", 32'(a_out_data), 32'h0);
        chk("arst_nb_data", 32'(n_out_data), 32'h0);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        chk("rst_hold_occ", 32'(a_occ), 32'd0);
        chk("rst_hold_stall", 32'(a_stall), 32'd0);
        rst = 1'b1;
        step(1'b1, 8'h90, 1'b0, 1'b0);
        chk("post_rst_occ", 32'(a_occ), 32'd1);
        chk("post_rst_data", 32'(a_out_data), 32'h90);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_drain", 32'(a_occ), 32'd0);
        chk("post_rst_stall", 32'(a_stall), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
